// File: rtl/mx_block_serializer.sv
// Serializes one MX block (shared scale + k signed elements) into a byte stream.
// Optional prefetch buffer for gapless back-to-back blocks: MXSER_PREFETCH_EN.
module mx_block_serializer #(
  parameter int bit_width = 8,
  parameter int k         = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic signed [bit_width-1:0] i_mx_vec [k],
  input  logic [7:0]                  i_mx_exp,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic [7:0]                  o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_first,
  output logic                        o_last
);

  localparam int IW = (k > 1) ? $clog2(k) : 1;
  localparam logic [IW-1:0] LAST = IW'(k - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    ELEM
  } state_t;

  state_t                      state;
  logic [IW-1:0]               idx;
  logic [IW-1:0]               nidx;
  logic [7:0]                  act_exp;
  logic signed [bit_width-1:0] act_vec [k];
  logic                        accept;
  logic                        take;
  logic                        last_take;

`ifdef MXSER_PREFETCH_EN
  logic [7:0]                  pend_exp;
  logic signed [bit_width-1:0] pend_vec [k];
  logic                        pend_full;

  assign o_ready = !pend_full;
`else
  assign o_ready = (state == IDLE);
`endif

  assign accept    = i_valid && o_ready;
  assign take      = o_valid && i_ready;
  assign last_take = take && (state == ELEM) && (idx == LAST);
  assign nidx      = idx + IW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      idx     <= '0;
      act_exp <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      for (int i = 0; i < k; i++) begin
        act_vec[i] <= '0;
      end
`ifdef MXSER_PREFETCH_EN
      pend_exp  <= '0;
      pend_full <= 1'b0;
      for (int i = 0; i < k; i++) begin
        pend_vec[i] <= '0;
      end
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            act_exp <= i_mx_exp;
            act_vec <= i_mx_vec;
            state   <= SCALE;
            o_valid <= 1'b1;
            o_data  <= i_mx_exp;
            o_first <= 1'b1;
            o_last  <= 1'b0;
          end
        end
        SCALE: begin
          if (take) begin
            state   <= ELEM;
            idx     <= '0;
            o_data  <= 8'(act_vec[0]);
            o_first <= 1'b0;
            o_last  <= (LAST == '0);
          end
        end
        ELEM: begin
          if (take) begin
            if (idx == LAST) begin
              idx    <= '0;
              o_last <= 1'b0;
`ifdef MXSER_PREFETCH_EN
              if (pend_full) begin
                act_exp   <= pend_exp;
                act_vec   <= pend_vec;
                pend_full <= 1'b0;
                state     <= SCALE;
                o_data    <= pend_exp;
                o_first   <= 1'b1;
              end else if (accept) begin
                act_exp <= i_mx_exp;
                act_vec <= i_mx_vec;
                state   <= SCALE;
                o_data  <= i_mx_exp;
                o_first <= 1'b1;
              end else begin
                state   <= IDLE;
                o_valid <= 1'b0;
                o_data  <= '0;
              end
`else
              state   <= IDLE;
              o_valid <= 1'b0;
              o_data  <= '0;
`endif
            end else begin
              idx    <= nidx;
              o_data <= 8'(act_vec[nidx]);
              o_last <= (nidx == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef MXSER_PREFETCH_EN
      // a block arriving mid-stream parks here unless the stream ends this edge
      if (accept && state != IDLE && !last_take) begin
        pend_exp  <= i_mx_exp;
        pend_vec  <= i_mx_vec;
        pend_full <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mx_block_serializer.sv
// Directed bench for mx_block_serializer: table-driven blocks plus
// back-to-back and mid-block reset sequences.
module tb_mx_block_serializer;

  logic              clk;
  logic              rst;
  logic signed [7:0] vec [32];
  logic [7:0]        exp_in;
  logic              in_valid;
  logic              out_ready;
  logic [7:0]        data;
  logic              out_valid;
  logic              ds_ready;
  logic              first;
  logic              last;

  logic signed [5:0] vec2 [2];
  logic [7:0]        exp2;
  logic              valid2;
  logic              ordy2;
  logic [7:0]        data2;
  logic              ovalid2;
  logic              first2;
  logic              last2;

  int nvec = 0;
  int nerr = 0;

  mx_block_serializer #(.bit_width(8), .k(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_mx_vec(vec), .i_mx_exp(exp_in),
    .i_valid(in_valid), .o_ready(out_ready), .o_data(data),
    .o_valid(out_valid), .i_ready(ds_ready), .o_first(first), .o_last(last)
  );

  mx_block_serializer #(.bit_width(6), .k(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_mx_vec(vec2), .i_mx_exp(exp2),
    .i_valid(valid2), .o_ready(ordy2), .o_data(data2),
    .o_valid(ovalid2), .i_ready(1'b1), .o_first(first2), .o_last(last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sc;
    int         pat;
    int         rmode;
  } blk_t;

  typedef struct {
    logic [7:0]        sc;
    logic signed [5:0] e0;
    logic signed [5:0] e1;
    logic [7:0]        x0;
    logic [7:0]        x1;
  } sx_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] elem(input int pat, input int i);
    case (pat)
      1:       return 8'h00;
      2:       return 8'(255 - i);
      default: return 8'(i);
    endcase
  endfunction

  task automatic stream(input logic [7:0] sc, input int pat, input int rmode,
                        input int rlow_req);
    logic [7:0] expb [33];
    logic [7:0] hd;
    logic       hf, hl, stalled, acc, got;
    int         beat, rlow;
    expb[0] = sc;
    for (int i = 0; i < 32; i++) begin
      expb[i+1] = elem(pat, i);
      vec[i]    = elem(pat, i);
    end
    exp_in   = sc;
    in_valid = 1'b1;
    beat = 0; rlow = 0; got = 1'b0; stalled = 1'b0;
    hd = '0; hf = 1'b0; hl = 1'b0;
    for (int c = 0; c < 600 && beat < 33; c++) begin
      if (stalled) begin
        chk("stall_data", data, hd);
        chk("stall_flags", {out_valid, first, last}, {1'b1, hf, hl});
      end
      if (got && !out_ready) rlow++;
      ds_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && ds_ready) begin
        chk($sformatf("beat%0d_data", beat), data, expb[beat]);
        chk($sformatf("beat%0d_first", beat), first, beat == 0);
        chk($sformatf("beat%0d_last", beat), last, beat == 32);
        beat++;
      end
      stalled = out_valid && !ds_ready;
      hd = data; hf = first; hl = last;
      acc = in_valid && out_ready;
      step();
      if (acc) begin
        in_valid = 1'b0;
        got      = 1'b1;
      end
    end
    chk("beat_count", beat, 33);
    if (rmode == 0) chk("ready_low_cycles", rlow, rlow_req);
    ds_ready = 1'b1;
    step();
    chk("idle_after_block", out_valid, 0);
  endtask

  task automatic run2(input sx_t r);
    logic [7:0] x [3];
    logic       acc;
    int         beat;
    x[0] = r.sc; x[1] = r.x0; x[2] = r.x1;
    vec2[0] = r.e0; vec2[1] = r.e1; exp2 = r.sc;
    valid2 = 1'b1;
    beat = 0;
    for (int c = 0; c < 20 && beat < 3; c++) begin
      if (ovalid2) begin
        chk($sformatf("sx_beat%0d_data", beat), data2, x[beat]);
        chk($sformatf("sx_beat%0d_first", beat), first2, beat == 0);
        chk($sformatf("sx_beat%0d_last", beat), last2, beat == 2);
        beat++;
      end
      acc = valid2 && ordy2;
      step();
      if (acc) valid2 = 1'b0;
    end
    chk("sx_beat_count", beat, 3);
    step();
  endtask

  blk_t tbl [4];
  sx_t  sxt [3];

  initial begin
    int         nf, nacc, gap_req, ebeat;
    int         fc [2];
    logic [7:0] fs [2];
    logic       pf, acc, hit;

    tbl[0] = '{sc: 8'h7A, pat: 0, rmode: 0};
    tbl[1] = '{sc: 8'h7A, pat: 0, rmode: 1};
    tbl[2] = '{sc: 8'hFF, pat: 1, rmode: 0};
    tbl[3] = '{sc: 8'h81, pat: 2, rmode: 1};

    sxt[0] = '{sc: 8'h11, e0: 6'b100000, e1: 6'b011111, x0: 8'hE0, x1: 8'h1F};
    sxt[1] = '{sc: 8'h22, e0: 6'b111111, e1: 6'b000001, x0: 8'hFF, x1: 8'h01};
    sxt[2] = '{sc: 8'hFF, e0: 6'b000000, e1: 6'b100001, x0: 8'h00, x1: 8'hE1};

`ifdef MXSER_PREFETCH_EN
    gap_req = 33;
`else
    gap_req = 34;
`endif

    rst = 1'b1; in_valid = 1'b0; ds_ready = 1'b1; exp_in = '0;
    valid2 = 1'b0; exp2 = '0;
    for (int i = 0; i < 32; i++) vec[i] = '0;
    vec2[0] = '0; vec2[1] = '0;
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_first", first, 0);
    chk("rst_last", last, 0);
    chk("rst_data", data, 0);
    chk("rst_ready", out_ready, 1);
    rst = 1'b0;
    step();

    for (int t = 0; t < 4; t++) begin
`ifdef MXSER_PREFETCH_EN
      stream(tbl[t].sc, tbl[t].pat, tbl[t].rmode, 0);
`else
      stream(tbl[t].sc, tbl[t].pat, tbl[t].rmode, 33);
`endif
    end

    for (int t = 0; t < 3; t++) run2(sxt[t]);

    // back-to-back: i_valid held, second block presented once first is taken
    for (int i = 0; i < 32; i++) vec[i] = elem(0, i);
    exp_in = 8'h10; in_valid = 1'b1; ds_ready = 1'b1;
    nf = 0; nacc = 0; pf = 1'b0;
    fc[0] = 0; fc[1] = 0; fs[0] = '0; fs[1] = '0;
    for (int c = 0; c < 200 && nf < 2; c++) begin
      if (out_valid && first && !pf) begin
        fc[nf] = c;
        fs[nf] = data;
        nf++;
      end
      pf  = out_valid && first;
      acc = in_valid && out_ready;
      step();
      if (acc) begin
        nacc++;
        if (nacc == 1) exp_in = 8'h20;
        else in_valid = 1'b0;
      end
    end
    chk("b2b_first_count", nf, 2);
    chk("b2b_scale0", fs[0], 8'h10);
    chk("b2b_scale1", fs[1], 8'h20);
    chk("b2b_gap", fc[1] - fc[0], gap_req);
    in_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (!out_valid) hit = 1'b1;
      else step();
    end
    chk("b2b_drained", hit, 1);

    // reset while element beat 5 is on the output
    for (int i = 0; i < 32; i++) vec[i] = elem(0, i);
    exp_in = 8'h33; in_valid = 1'b1; ds_ready = 1'b1;
    ebeat = 0; hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (out_valid && !first) begin
        if (ebeat == 5) hit = 1'b1;
        else ebeat++;
      end
      if (!hit) begin
        acc = in_valid && out_ready;
        step();
        if (acc) in_valid = 1'b0;
      end
    end
    chk("rst_mid_reached", hit, 1);
    chk("rst_mid_beat5", data, 8'h05);
    rst = 1'b1;
    step();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", out_ready, 1);
    chk("rst_mid_first", first, 0);
    chk("rst_mid_last", last, 0);
    rst = 1'b0;
`ifdef MXSER_PREFETCH_EN
    stream(8'h55, 0, 0, 0);
`else
    stream(8'h55, 0, 0, 33);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
